// File: rtl/mem_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_pkg
// Description : Shared types and helpers for the RAM built-in self-test
//               initiator. It holds the FSM state encoding and the
//               expected-data pattern function.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_test_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Pattern word for one address. The caller truncates the result to its
  // data width, which gives the mod 2^DW wrap. When inv is set, the result is
  // the bitwise complement, so the second pass drives every bit to the
  // opposite polarity.
  function automatic logic [31:0] exp_data(input logic [31:0] seed,
                                           input logic [31:0] addr,
                                           input logic [31:0] step,
                                           input logic        inv);
    logic [31:0] v;
    v = seed + addr * step;
    return inv ? ~v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_test_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_checker
// Description : One-stage compare pipeline for the RAM self-test. It carries
//               the address and expected word of each read issue for one cycle,
//               so the compare lines up with the registered RAM read data. It
//               also holds the saturating error counter and the first-error
//               address latch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_test_checker #(
  parameter int AW    = 2,
  parameter int DW    = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             issue_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [DW-1:0]    exp_i,
  input  logic [DW-1:0]    rdata_i,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [AW-1:0]    first_err_addr_o,
  output logic             clean_next_o
);

  logic             valid_q;
  logic [AW-1:0]    paddr_q;
  logic [DW-1:0]    pexp_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0]    first_q, first_d;
  logic             seen_q, seen_d;
  logic             w_mismatch;

  // Compare against the word issued in the previous cycle. The case-inequality
  // makes X read data count as a mismatch.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    seen_d     = seen_q;
    w_mismatch = valid_q && (rdata_i !== pexp_q);
    if (clr_i) begin
      err_cnt_d = '0;
      first_d   = '0;
      seen_d    = 1'b0;
    end else if (w_mismatch) begin
      if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (!seen_q) begin
        first_d = paddr_q;
        seen_d  = 1'b1;
      end
    end
  end

  // Pipeline stage and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      paddr_q   <= '0;
      pexp_q    <= '0;
      err_cnt_q <= '0;
      first_q   <= '0;
      seen_q    <= 1'b0;
    end else begin
      valid_q   <= issue_i && !clr_i;
      paddr_q   <= addr_i;
      pexp_q    <= exp_i;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      seen_q    <= seen_d;
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_q;
  // Error-free status that includes the compare resolving this cycle. The
  // top level uses it to load pass on entry to DONE.
  assign clean_next_o     = (err_cnt_d == '0);

endmodule
`default_nettype wire

// File: rtl/mem_test_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_initiator
// Description : Built-in self-test sequencer for a single-port synchronous
//               RAM. It writes seed + a*STEP to every address, reads each one
//               back through a one-cycle compare pipeline, and reports pass and
//               an error count.
//               Define MEM_TEST_INVERT_PASS_EN to add a second pass that uses
//               the complemented pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_test_initiator
  import mem_test_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 8,
  parameter int STEP  = 11,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] seed_q, seed_d;
  logic          inv_q, inv_d;
  logic          pass_q, pass_d;
  logic          busy_q, done_q, mem_we_q;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          w_last, w_clr, w_issue, w_clean_next;
  logic [DW-1:0] w_rd_exp;

  // Next-state and address sequencing. The transition is keyed on the last
  // address, not on counter overflow.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    inv_d   = inv_q;
    pass_d  = pass_q;
    w_clr   = 1'b0;
    w_last  = (addr_q == AW'(DEPTH - 1));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          addr_d  = '0;
          seed_d  = seed;
          inv_d   = 1'b0;
          pass_d  = 1'b0;
          w_clr   = 1'b1;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (w_last) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        if (w_last) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end
      end
      S_DRAIN: begin
`ifdef MEM_TEST_INVERT_PASS_EN
        if (!inv_q) begin
          state_d = S_WRITE;
          inv_d   = 1'b1;
        end else begin
          state_d = S_DONE;
          pass_d  = w_clean_next;
        end
`else
        state_d = S_DONE;
        pass_d  = w_clean_next;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The RAM-facing outputs are computed from next state so that they come
  // straight from flops and line up with the state register.
  always_comb begin
    mem_wdata_d = '0;
    if (state_d == S_WRITE) begin
      mem_wdata_d = DW'(exp_data(32'(seed_d), 32'(addr_d), 32'(STEP), inv_d));
    end
  end

  assign w_issue  = (state_q == S_READ);
  assign w_rd_exp = DW'(exp_data(32'(seed_q), 32'(addr_q), 32'(STEP), inv_q));

  // State, sequencing and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      inv_q       <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      inv_q       <= inv_d;
      pass_q      <= pass_d;
      busy_q      <= (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_DONE);
      mem_we_q    <= (state_d == S_WRITE);
      mem_wdata_q <= mem_wdata_d;
    end
  end

  mem_test_checker #(
    .AW    (AW),
    .DW    (DW),
    .ERR_W (ERR_W)
  ) u_checker (
    .clk              (clk),
    .rst_n            (rst_n),
    .clr_i            (w_clr),
    .issue_i          (w_issue),
    .addr_i           (addr_q),
    .exp_i            (w_rd_exp),
    .rdata_i          (mem_rdata),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr),
    .clean_next_o     (w_clean_next)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_test_initiator
// Description : Self-checking bench for mem_test_initiator. A behavioural RAM
//               with stuck-at fault masks sits beside the DUT. A reference
//               model derives the expected write sequence, latency and result
//               from the pattern rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_test_initiator;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int STEP  = 11;
  localparam int ERR_W = 8;
`ifdef MEM_TEST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LAT = (NPASS == 2) ? 4 * DEPTH + 3 : 2 * DEPTH + 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [DW-1:0]    seed;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_cnt;
  logic [AW-1:0]    first_err_addr;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_test_initiator #(
    .DEPTH (DEPTH), .AW (AW), .DW (DW), .STEP (STEP), .ERR_W (ERR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with per-address stuck-at-1 / stuck-at-0 masks.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] sa1 [DEPTH];
  logic [DW-1:0] sa0 [DEPTH];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= (mem_wdata | sa1[mem_addr]) & ~sa0[mem_addr];
    else        mem_rdata     <= ram[mem_addr];
  end

  // Reference model results
  int m_err, m_first;
  logic m_pass;
  int wq_a[$];
  int wq_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      sa1[a] = '0;
      sa0[a] = '0;
    end
  endtask

  // Expected writes and result for one run: every pass writes each address
  // once, and a mismatch is any stored word that differs from the one written.
  task automatic model(input int s);
    bit found;
    wq_a.delete();
    wq_d.delete();
    m_err = 0;
    m_first = 0;
    found = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        int e, st;
        e = (s + a * STEP) % 256;
        if (p == 1) e = 255 - e;
        wq_a.push_back(a);
        wq_d.push_back(e);
        st = (e | int'(sa1[a])) & ~int'(sa0[a]) & 255;
        if (st != e) begin
          if (m_err < 255) m_err++;
          if (!found) begin
            m_first = a;
            found = 1;
          end
        end
      end
    end
    m_pass = (m_err == 0);
  endtask

  // One full run, starting from IDLE. poke > 0 pulses start at that busy cycle.
  task automatic do_run(input int s, input int poke);
    int cyc, wi;
    bit seen;
    model(s);
    seed  = DW'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed  = DW'($urandom);
    cyc = 1; wi = 0; seen = 0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err_cnt, 0);
    check("pass_cleared", pass, 0);
    check("first_cleared", first_err_addr, 0);
    while (!seen && cyc <= LAT + 5) begin
      if (mem_we) begin
        if (wi < wq_a.size()) begin
          check("wr_addr", mem_addr, wq_a[wi]);
          check("wr_data", mem_wdata, wq_d[wi]);
        end else begin
          check("write_overrun", wi + 1, wq_a.size());
        end
        wi++;
      end
      if (done) begin
        seen = 1;
      end else begin
        if (cyc == poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    check("done_seen", seen, 1);
    check("latency", cyc, LAT);
    check("busy_at_done", busy, 0);
    check("pass", pass, m_pass);
    check("err_cnt", err_cnt, m_err);
    check("first_err_addr", first_err_addr, m_first);
    check("write_count", wi, wq_a.size());
  endtask

  // Cycle after DONE: the done pulse is gone, the FSM is idle and pass holds.
  // poke drives start during the DONE cycle, and that start must be ignored.
  task automatic after_done(input bit poke);
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    check("pass_hold", pass, m_pass);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_first"}, first_err_addr, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int done_hits;
    rst_n = 1'b0;
    start = 1'b0;
    seed  = '0;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // Clean pattern from seed 0.
    do_run(0, 0);
    after_done(0);

    // Stuck-at-1 on bit 0 of address 2.
    sa1[2] = 8'h01;
    do_run(0, 0);
    after_done(0);
    clear_faults();

    // Pattern wraps mod 256.
    do_run(250, 0);
    after_done(0);

    // Start pulses while busy and in DONE are ignored. The next IDLE start runs
    // a fresh sequence with the error state cleared.
    sa1[1] = 8'h80;
    do_run(77, 3);
    after_done(1);
    clear_faults();
    do_run(77, 0);
    after_done(0);

    // Reset in the middle of READ, after one mismatch has been counted.
    sa0[0] = 8'hFF;
    model(33);
    seed  = 8'd33;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_read_err", err_cnt, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    done_hits = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_hits++;
    end
    check("no_done_in_reset", done_hits, 0);
    rst_n = 1'b1;
    clear_faults();
    @(posedge clk); #1;
    check("idle_after_reset", busy, 0);
    do_run(33, 0);
    after_done(0);

    // Randomized seeds and faults.
    for (int it = 0; it < 12; it++) begin
      clear_faults();
      for (int f = 0; f < 2; f++) begin
        if ($urandom_range(0, 1) == 1) begin
          int a, b;
          a = $urandom_range(0, DEPTH - 1);
          b = $urandom_range(0, DW - 1);
          if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
          else                           sa0[a][b] = 1'b1;
        end
      end
      do_run($urandom_range(0, 255), 0);
      after_done(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
